// File: rtl/rr_grant_lock_if.sv
// rr_grant_lock_if
//   Request/grant bundle between the requesters of one router output and
//   the round-robin grant controller that arbitrates them.
//   req_vec     per-requester flit valid
//   req_last    per-requester "current flit is the last of its packet"
//   gnt_ready   downstream accepts the granted flit this cycle
//   gnt_vec     one-hot grant, all-zero while idle
//   gnt_valid   a grant is currently held
//   start_entry one-hot rotating priority pointer
//   timeout_err one-cycle pulse after a stalled grant is force-released
//   master: requester/downstream side; slave: the grant controller.
interface rr_grant_lock_if #(
    parameter int ENTRIES_NUM = 4
);
    logic [ENTRIES_NUM-1:0] req_vec;
    logic [ENTRIES_NUM-1:0] req_last;
    logic                   gnt_ready;
    logic [ENTRIES_NUM-1:0] gnt_vec;
    logic                   gnt_valid;
    logic [ENTRIES_NUM-1:0] start_entry;
    logic                   timeout_err;

    modport master (
        output req_vec, req_last, gnt_ready,
        input  gnt_vec, gnt_valid, start_entry, timeout_err
    );

    modport slave (
        input  req_vec, req_last, gnt_ready,
        output gnt_vec, gnt_valid, start_entry, timeout_err
    );
endinterface

// File: rtl/rr_grant_lock.sv
// rr_grant_lock
//   Round-robin grant controller for one router output. Holds a registered
//   one-hot grant for a whole packet, advances priority to one past the
//   winner on release, and force-releases a grant that stalls for
//   TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES = 0 disables the watchdog).
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : rr_grant_lock_if.slave (requests in, grant/pointer/error out)
module rr_grant_lock #(
    parameter int ENTRIES_NUM    = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst,
    rr_grant_lock_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
    localparam logic [ENTRIES_NUM-1:0] ONE     = ENTRIES_NUM'(1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Lowest set request at or above the pointer, else lowest set overall.
    // x & (~x + 1) isolates the lowest set bit.
    function automatic logic [ENTRIES_NUM-1:0] rr_select(
        input logic [ENTRIES_NUM-1:0] req,
        input logic [ENTRIES_NUM-1:0] start
    );
        logic [ENTRIES_NUM-1:0] upper;
        upper = req & ~(start - ONE);
        if (|upper) begin
            return upper & (~upper + ONE);
        end
        return req & (~req + ONE);
    endfunction

    state_t                 state_q, state_d;
    logic [ENTRIES_NUM-1:0] gnt_q, gnt_d;
    logic [ENTRIES_NUM-1:0] start_q, start_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   terr_q, terr_d;

    logic                   found;
    logic                   xfer;
    logic                   done;
    logic                   tmo;
    logic [ENTRIES_NUM-1:0] rot;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;

        found = |bus.req_vec;
        // gnt_q is one-hot, so masking and OR-reducing picks the owner's bit.
        xfer  = (|(bus.req_vec & gnt_q)) & bus.gnt_ready;
        done  = xfer & (|(bus.req_last & gnt_q));
        // A transfer in the same cycle always cancels the timeout.
        tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !xfer;
        rot   = {gnt_q[ENTRIES_NUM-2:0], gnt_q[ENTRIES_NUM-1]};

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    gnt_d   = rr_select(bus.req_vec, start_q);
                    state_d = LOCK;
                end else begin
                    gnt_d = '0;
                end
            end
            LOCK: begin
                if (done || tmo) begin
                    // Release and re-arbitrate with the advanced pointer in the
                    // same cycle so back-to-back packets have no bubble.
                    start_d = rot;
                    terr_d  = tmo;
                    cnt_d   = '0;
                    gnt_d   = rr_select(bus.req_vec, rot);
                    state_d = found ? LOCK : IDLE;
                end else if (xfer || (TIMEOUT_CYCLES == 0)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            start_q <= ONE;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.gnt_vec     = gnt_q;
    assign bus.gnt_valid   = (state_q == LOCK);
    assign bus.start_entry = start_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_rr_grant_lock.sv
// tb_rr_grant_lock
//   Drives two controllers (watchdog disabled, and TIMEOUT_CYCLES = 4) from
//   the same requests and compares them every cycle against a packet-level
//   reference model that tracks owner index, pointer index and stall count.
module tb_rr_grant_lock;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_r;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         rdy;

    int total = 0;
    int bad   = 0;

    rr_grant_lock_if #(.ENTRIES_NUM(N)) bus0 ();
    rr_grant_lock_if #(.ENTRIES_NUM(N)) bus4 ();

    assign bus0.req_vec   = req;
    assign bus0.req_last  = last;
    assign bus0.gnt_ready = rdy;
    assign bus4.req_vec   = req;
    assign bus4.req_last  = last;
    assign bus4.gnt_ready = rdy;

    rr_grant_lock #(.ENTRIES_NUM(N), .TIMEOUT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst_r),
        .bus (bus0)
    );

    rr_grant_lock #(.ENTRIES_NUM(N), .TIMEOUT_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst_r),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    logic [N-1:0] o_gnt[2];
    logic         o_vld[2];
    logic [N-1:0] o_start[2];
    logic         o_terr[2];

    assign o_gnt[0]   = bus0.gnt_vec;
    assign o_vld[0]   = bus0.gnt_valid;
    assign o_start[0] = bus0.start_entry;
    assign o_terr[0]  = bus0.timeout_err;
    assign o_gnt[1]   = bus4.gnt_vec;
    assign o_vld[1]   = bus4.gnt_valid;
    assign o_start[1] = bus4.start_entry;
    assign o_terr[1]  = bus4.timeout_err;

    // Reference model state: owner = -1 when idle.
    int    tmo_cfg[2] = '{0, 4};
    string nm[2]      = '{"t0", "t4"};
    int    owner[2];
    int    ptr[2];
    int    stall[2];
    bit    terr[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_update(input int k);
        bit xf, dn, to;
        if (rst_r) begin
            owner[k] = -1;
            ptr[k]   = 0;
            stall[k] = 0;
            terr[k]  = 0;
        end else if (owner[k] < 0) begin
            terr[k]  = 0;
            stall[k] = 0;
            owner[k] = pick(req, ptr[k]);
        end else begin
            xf = req[owner[k]] && rdy;
            dn = xf && last[owner[k]];
            to = (tmo_cfg[k] != 0) && (stall[k] == tmo_cfg[k] - 1) && !xf;
            terr[k] = to;
            if (dn || to) begin
                ptr[k]   = (owner[k] + 1) % N;
                owner[k] = pick(req, ptr[k]);
                stall[k] = 0;
            end else if (xf || tmo_cfg[k] == 0) begin
                stall[k] = 0;
            end else begin
                stall[k] = stall[k] + 1;
            end
        end
    endtask

    // One clock: model advances on the edge, outputs are sampled 1 time unit
    // later, and control returns at the following falling edge for new drive.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk({nm[k], ".gnt_vec"}, 32'(o_gnt[k]),
                (owner[k] < 0) ? 32'd0 : (32'd1 << owner[k]));
            chk({nm[k], ".gnt_valid"}, 32'(o_vld[k]), 32'(owner[k] >= 0));
            chk({nm[k], ".start_entry"}, 32'(o_start[k]), 32'd1 << ptr[k]);
            chk({nm[k], ".timeout_err"}, 32'(o_terr[k]), 32'(terr[k]));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_r = 1'b1;
        req   = '0;
        last  = '0;
        rdy   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            ptr[k]   = 0;
            stall[k] = 0;
            terr[k]  = 0;
        end
        @(negedge clk);

        // Reset with all requesting, then first grant.
        req  = 4'b1111;
        last = 4'b1111;
        step();
        step();
        chk("rst_gnt", 32'(o_gnt[0]), 32'h0);
        chk("rst_vld", 32'(o_vld[0]), 32'h0);
        chk("rst_start", 32'(o_start[0]), 32'h1);
        rst_r = 1'b0;
        step();
        chk("first_gnt", 32'(o_gnt[0]), 32'h1);

        // Rotation: one grant per cycle, no bubbles.
        rdy = 1'b1;
        begin
            logic [N-1:0] seq[4];
            seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 4; i++) begin
                step();
                chk("rot_gnt", 32'(o_gnt[0]), 32'(seq[i]));
                chk("rot_vld", 32'(o_vld[0]), 32'h1);
            end
        end

        // Multi-flit lock on entry 1 while others request.
        rst_r = 1'b1; req = '0; rdy = 1'b0;
        step();
        rst_r = 1'b0; req = 4'b0010;
        step();
        chk("mf_grant", 32'(o_gnt[0]), 32'h2);
        req = 4'b1011; last = 4'b0000; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mf_hold", 32'(o_gnt[0]), 32'h2);
        end
        last = 4'b0010;
        step();
        chk("mf_next_gnt", 32'(o_gnt[0]), 32'h8);
        chk("mf_next_start", 32'(o_start[0]), 32'h4);

        // Backpressure with watchdog disabled.
        last = 4'b0000; rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_gnt", 32'(o_gnt[0]), 32'h8);
            chk("bp_start", 32'(o_start[0]), 32'h4);
            chk("bp_terr", 32'(o_terr[0]), 32'h0);
        end

        // Watchdog: entry 2 stalls, entry 0 pending.
        rst_r = 1'b1; req = '0;
        step();
        rst_r = 1'b0; req = 4'b0100;
        step();
        chk("wd_grant", 32'(o_gnt[1]), 32'h4);
        req = 4'b0001; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_hold", 32'(o_gnt[1]), 32'h4);
            chk("wd_noterr", 32'(o_terr[1]), 32'h0);
        end
        step();
        chk("wd_terr", 32'(o_terr[1]), 32'h1);
        chk("wd_start", 32'(o_start[1]), 32'h8);
        chk("wd_gnt", 32'(o_gnt[1]), 32'h1);
        rdy = 1'b0;
        step();
        chk("wd_pulse_end", 32'(o_terr[1]), 32'h0);

        // Wrap past the top entry, then sole requester re-granted.
        rst_r = 1'b1; req = '0;
        step();
        rst_r = 1'b0; req = 4'b0100;
        step();
        req = 4'b0110; last = 4'b0100; rdy = 1'b1;
        step();
        chk("wrap_gnt", 32'(o_gnt[0]), 32'h2);
        chk("wrap_start", 32'(o_start[0]), 32'h8);
        req = 4'b0010; last = 4'b0010;
        step();
        chk("sole_gnt", 32'(o_gnt[0]), 32'h2);
        chk("sole_start", 32'(o_start[0]), 32'h4);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst_r = ($urandom_range(0, 63) == 0);
            req   = 4'($urandom);
            last  = 4'($urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_grant_lock.md
# rr_grant_lock

Stateful round-robin grant controller that drives the rotating-priority search from the router's per-output arbitration path. It owns the start pointer, issues a registered one-hot grant, and holds the grant across a multi-flit packet until the last flit is accepted downstream. After each packet it advances priority to one past the winner. A per-grant stall watchdog force-releases a requester that stops making progress.

## Interface
- ENTRIES_NUM, 4, number of requesters (>=2)
- TIMEOUT_CYCLES, 0, stall cycles before forced release; 0 disables the watchdog
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_vec  in  ENTRIES_NUM  per-requester flit-valid
- req_last  in  ENTRIES_NUM  per-requester "current flit is last of packet"
- gnt_ready  in  1  downstream accepts the granted flit this cycle
- gnt_vec  out  ENTRIES_NUM  registered one-hot grant (all-zero when idle)
- gnt_valid  out  1  grant held (state LOCK)
- start_entry  out  ENTRIES_NUM  registered one-hot priority pointer
- timeout_err  out  1  one-cycle pulse on forced release

## Operation
- Reset values: state IDLE; gnt_vec=0; gnt_valid=0; start_entry=1 (entry 0); timeout_err=0; stall counter=0.
- Selection function: pick the lowest-index set bit of req_vec at or above start_entry. If none, pick the lowest-index set bit overall (wrap). found = |req_vec.
- IDLE
  - If found: load gnt_vec=sel and enter LOCK.
  - Otherwise stay in IDLE.
- LOCK
  - gnt_valid=1. Let g be the granted index.
  - xfer = req_vec[g] & gnt_ready. done = xfer & req_last[g].
- Release occurs on done, or on timeout (TIMEOUT_CYCLES!=0, counter==TIMEOUT_CYCLES-1, and !xfer).
- On release:
  - start_entry becomes gnt_vec rotated left by 1 (MSB wraps to bit 0).
  - In the same cycle, re-run selection over the current req_vec using the new pointer. If found, reload gnt_vec and stay in LOCK; else gnt_vec=0 and go to IDLE.
  - If the released requester is the only one requesting, it is re-granted.
- Stall counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Cleared on xfer and on any new grant; otherwise increments each LOCK cycle.
  - Held at 0 when the watchdog is disabled.
- timeout_err is registered: high for exactly the cycle after a timeout release. On a cycle where done and the timeout condition coincide, done wins (xfer is true, so no timeout).
- While in LOCK, req_vec changes on other entries do not affect gnt_vec. Deasserting req_vec[g] mid-packet keeps the lock and only stalls it (the watchdog eventually applies).
- start_entry changes only on release, never in IDLE.
- rst asserted in any state returns all outputs to reset values on the next edge; a packet in flight is abandoned.

## Timing
- Request to grant: req_vec asserted in cycle t while IDLE gives gnt_valid/gnt_vec in cycle t+1.
- Back-to-back packets: a release in cycle t with other requests pending shows the new gnt_vec in t+1, with no idle bubble.
- Single-flit packet (req_last=1, gnt_ready=1) occupies the grant exactly one cycle.
- Timeout: with a new grant at cycle t and no xfer, release occurs at the edge ending cycle t+TIMEOUT_CYCLES-1. timeout_err=1 and the new grant (or idle) apply in cycle t+TIMEOUT_CYCLES.
- gnt_ready is used only when gnt_valid=1; it is ignored in IDLE.

## Test plan
- **Reset/idle:** assert rst 2 cycles with req_vec=4'b1111 -> gnt_vec=0, gnt_valid=0, start_entry=4'b0001; deassert rst -> gnt_vec=4'b0001 the next cycle.
- **Rotation:** req_vec=4'b1111, req_last=4'b1111, gnt_ready=1 continuously -> gnt_vec sequence 0001, 0010, 0100, 1000, 0001, with one grant per cycle and no bubbles.
- **Multi-flit lock:** grant entry 1 with req_last[1]=0 for 3 flits then 1. Meanwhile req_vec=4'b1011 -> gnt_vec stays 0010 for 4 accepted flits, then becomes 1000, and start_entry=4'b0100.
- **Backpressure:** gnt_ready=0 for 5 cycles mid-packet with TIMEOUT_CYCLES=0 -> grant held, start_entry unchanged, no timeout_err.
- **Watchdog:** TIMEOUT_CYCLES=4, entry 2 granted, req_vec[2] dropped -> release after 4 cycles, timeout_err pulses one cycle, start_entry=4'b1000, and a pending entry 0 is granted in the same cycle as the pulse.
- **Wrap and sole requester:** start_entry=4'b1000, req_vec=4'b0010 -> entry 1 granted; on completion with only entry 1 still requesting -> entry 1 is re-granted the next cycle.
